// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router widths, defaults and buffer op encoding
package router_pkg;

  localparam int ROUTER_FLIT_W = 16;
  localparam int ROUTER_DEPTH  = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // A single-entry buffer still needs a one-bit pointer port on the RAM.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// rtl/router_fifo_ram.sv - flit storage, synchronous write, asynchronous read
module router_fifo_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/router_in_fifo.sv
// rtl/router_in_fifo.sv - router input port flit buffer; ROUTER_FIFO_STATS_EN adds stall_cnt
module router_in_fifo
  import router_pkg::*;
#(
  parameter int FLIT_W = ROUTER_FLIT_W,
  parameter int DEPTH  = ROUTER_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [FLIT_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          req,
  input  logic                          block,
  output logic [FLIT_W-1:0]             out_data,
  output logic [cnt_width(DEPTH)-1:0]   count
`ifdef ROUTER_FIFO_STATS_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic     w_push;
  logic     w_pop;
  fifo_op_e w_op;

  // Handshake outputs depend on registered occupancy only, keeping in_valid
  // and block out of any combinational loop through the arbiter.
  assign in_ready = (r_count != CW'(DEPTH));
  assign req      = (r_count != '0);
  assign count    = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = req & ~block;
  assign w_op   = fifo_op_e'({w_pop, w_push});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case (w_op)
        OP_PUSH: r_count <= r_count + 1'b1;
        OP_POP:  r_count <= r_count - 1'b1;
        OP_IDLE,
        OP_BOTH: r_count <= r_count;
      endcase
    end
  end

  router_fifo_ram #(
    .W     (FLIT_W),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (out_data)
  );

`ifdef ROUTER_FIFO_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (req && block && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_router_in_fifo.sv
// tb/tb_router_in_fifo.sv - self-checking bench for router_in_fifo (ROUTER_FIFO_STATS_EN optional)
module tb_router_in_fifo;

  localparam int FW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic          in_ready;
  logic          req;
  logic          block = 1'b1;
  logic [FW-1:0] out_data;
  logic [2:0]    count;
`ifdef ROUTER_FIFO_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [FW-1:0] q[$];

  always #5 clk = ~clk;

  router_in_fifo #(.FLIT_W(FW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .req      (req),
    .block    (block),
    .out_data (out_data),
    .count    (count)
`ifdef ROUTER_FIFO_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: a buffer of DP flits, head leaves when present and not blocked.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      int sz;
      bit do_push;
      sz = q.size();
      do_push = in_valid && (sz < DP);
      if (sz > 0 && !block) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_count", 32'(count), 32'(q.size()));
      chk("model_req", 32'(req), 32'(q.size() != 0));
      chk("model_in_ready", 32'(in_ready), 32'(q.size() != DP));
      if (q.size() != 0) chk("model_out_data", 32'(out_data), 32'(q[0]));
    end
  end

  task automatic tick(input logic v, input logic [FW-1:0] d, input logic b);
    in_valid = v;
    in_data  = d;
    block    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill with the head blocked.
    for (int i = 1; i <= 4; i++) tick(1'b1, FW'(i), 1'b1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_req", 32'(req), 32'd1);
    chk("fill_head", 32'(out_data), 32'h0001);
    tick(1'b1, 16'hDEAD, 1'b1);
    chk("full_ignore_count", 32'(count), 32'd4);
    chk("full_ignore_head", 32'(out_data), 32'h0001);

    // Drain in order.
    for (int i = 2; i <= 4; i++) begin
      tick(1'b0, '0, 1'b0);
      chk("drain_head", 32'(out_data), 32'(i));
    end
    tick(1'b0, '0, 1'b0);
    chk("drain_req", 32'(req), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    tick(1'b0, '0, 1'b0);
    chk("empty_no_pop", 32'(count), 32'd0);

    // Concurrent push/pop holding occupancy at 2.
    tick(1'b1, 16'h0010, 1'b1);
    tick(1'b1, 16'h0011, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, FW'(16'h0012 + k), 1'b0);
      chk("conc_count", 32'(count), 32'd2);
      chk("conc_head", 32'(out_data), 32'(16'h0011 + k));
    end
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    chk("conc_drained", 32'(count), 32'd0);

    // Simultaneous push/pop at count=1 and count=DEPTH-1.
    tick(1'b1, 16'h0031, 1'b1);
    tick(1'b1, 16'h0032, 1'b0);
    chk("both_at_1_count", 32'(count), 32'd1);
    chk("both_at_1_head", 32'(out_data), 32'h0032);
    tick(1'b1, 16'h0033, 1'b1);
    tick(1'b1, 16'h0034, 1'b1);
    tick(1'b1, 16'h0035, 1'b0);
    chk("both_at_3_count", 32'(count), 32'd3);
    chk("both_at_3_head", 32'(out_data), 32'h0033);
    repeat (3) tick(1'b0, '0, 1'b0);
    chk("both_drained", 32'(count), 32'd0);

    // Nine push/pop pairs wrap the pointers twice.
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, FW'(16'h0100 + i), 1'b1);
      chk("wrap_head", 32'(out_data), 32'(16'h0100 + i));
      tick(1'b0, '0, 1'b0);
    end
    chk("wrap_empty", 32'(count), 32'd0);

    // Reset with three flits buffered.
    tick(1'b1, 16'h00A1, 1'b1);
    tick(1'b1, 16'h00A2, 1'b1);
    tick(1'b1, 16'h00A3, 1'b1);
    chk("pre_reset_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_req", 32'(req), 32'd0);
    chk("async_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 16'h0055, 1'b1);
    chk("post_reset_push_count", 32'(count), 32'd1);
    chk("post_reset_head", 32'(out_data), 32'h0055);
    tick(1'b0, '0, 1'b0);
    chk("post_reset_empty", 32'(req), 32'd0);
    repeat (2) tick(1'b0, '0, 1'b0);
    chk("no_stale_flits", 32'(req), 32'd0);

`ifdef ROUTER_FIFO_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("stall_reset", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 16'h0077, 1'b1);
    chk("stall_first", 32'(stall_cnt), 32'd0);
    tick(1'b0, '0, 1'b1);
    chk("stall_one", 32'(stall_cnt), 32'd1);
    repeat (70000) tick(1'b0, '0, 1'b1);
    chk("stall_saturate", 32'(stall_cnt), 32'hFFFF);
    repeat (5) tick(1'b0, '0, 1'b1);
    chk("stall_hold", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
